// File: rtl/indicador_alarma_descarga.sv
`default_nettype none
// ============================================================================
//  Module      : indicador_alarma_descarga
//  Description : Filters the battery discharge flag over a slow sample strobe,
//                raises an alarm after FILTER_LEN consecutive flagged ticks,
//                blinks the user LED until acknowledged, holds it steady once
//                acknowledged, and clears after CLEAR_LEN unflagged ticks.
//                Optional macro ALARMA_CONTADOR_EN adds eventos_o, a
//                saturating count of entries into ALARMA since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module indicador_alarma_descarga #(
    parameter int FILTER_LEN = 4,
    parameter int BLINK_HALF = 2,
    parameter int CLEAR_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic       descarga_i,
    input  logic       ack_i,
    output logic       led_o,
    output logic       alarma_o,
    output logic [1:0] estado_o
`ifdef ALARMA_CONTADOR_EN
    ,
    output logic [7:0] eventos_o
`endif
);

    localparam logic [1:0] c_NORMAL     = 2'b00;
    localparam logic [1:0] c_PENDIENTE  = 2'b01;
    localparam logic [1:0] c_ALARMA     = 2'b10;
    localparam logic [1:0] c_RECONOCIDA = 2'b11;

    localparam logic [7:0] c_FILTER_LEN = 8'(FILTER_LEN);
    localparam logic [7:0] c_BLINK_LAST = 8'(BLINK_HALF - 1);
    localparam logic [7:0] c_CLEAR_LEN  = 8'(CLEAR_LEN);

    logic [1:0] r_estado;
    logic [7:0] r_cnt_filt;
    logic [7:0] r_cnt_blink;
    logic [7:0] r_cnt_clear;
    logic       r_led;
    logic       r_alarma;

    logic [1:0] w_estado_nxt;
    logic [7:0] w_cnt_filt_nxt;
    logic [7:0] w_cnt_blink_nxt;
    logic [7:0] w_cnt_clear_nxt;
    logic       w_led_nxt;
    logic       w_alarma_nxt;
    logic       w_entra_alarma;
    logic       w_clear_fin;

    // Next-state and counter logic; clear completion outranks acknowledge,
    // and entering ALARMA overrides everything with a fresh alarm setup.
    always_comb begin
        w_estado_nxt    = r_estado;
        w_cnt_filt_nxt  = r_cnt_filt;
        w_cnt_blink_nxt = r_cnt_blink;
        w_cnt_clear_nxt = r_cnt_clear;
        w_led_nxt       = r_led;
        w_alarma_nxt    = r_alarma;
        w_entra_alarma  = 1'b0;
        w_clear_fin     = 1'b0;

        case (r_estado)
            c_NORMAL: begin
                if (tick_i && descarga_i) begin
                    if (c_FILTER_LEN == 8'd1) begin
                        w_entra_alarma = 1'b1;
                    end else begin
                        w_estado_nxt   = c_PENDIENTE;
                        w_cnt_filt_nxt = 8'd1;
                    end
                end
            end

            c_PENDIENTE: begin
                if (tick_i) begin
                    if (!descarga_i) begin
                        w_cnt_filt_nxt = 8'd0;
                        w_estado_nxt   = c_NORMAL;
                    end else if (r_cnt_filt + 8'd1 == c_FILTER_LEN) begin
                        w_entra_alarma = 1'b1;
                    end else begin
                        w_cnt_filt_nxt = r_cnt_filt + 8'd1;
                    end
                end
            end

            c_ALARMA, c_RECONOCIDA: begin
                if (tick_i) begin
                    if (descarga_i) begin
                        w_cnt_clear_nxt = 8'd0;
                    end else if (r_cnt_clear + 8'd1 == c_CLEAR_LEN) begin
                        w_clear_fin = 1'b1;
                    end else begin
                        w_cnt_clear_nxt = r_cnt_clear + 8'd1;
                    end
                end

                if (w_clear_fin) begin
                    w_estado_nxt    = c_NORMAL;
                    w_cnt_filt_nxt  = 8'd0;
                    w_cnt_blink_nxt = 8'd0;
                    w_cnt_clear_nxt = 8'd0;
                    w_led_nxt       = 1'b0;
                    w_alarma_nxt    = 1'b0;
                end else if (r_estado == c_ALARMA) begin
                    if (ack_i) begin
                        w_estado_nxt    = c_RECONOCIDA;
                        w_led_nxt       = 1'b1;
                        w_cnt_blink_nxt = 8'd0;
                    end else if (tick_i) begin
                        if (r_cnt_blink == c_BLINK_LAST) begin
                            w_led_nxt       = ~r_led;
                            w_cnt_blink_nxt = 8'd0;
                        end else begin
                            w_cnt_blink_nxt = r_cnt_blink + 8'd1;
                        end
                    end
                end
            end

            default: begin
                w_estado_nxt = c_NORMAL;
            end
        endcase

        if (w_entra_alarma) begin
            w_estado_nxt    = c_ALARMA;
            w_led_nxt       = 1'b1;
            w_alarma_nxt    = 1'b1;
            w_cnt_filt_nxt  = 8'd0;
            w_cnt_blink_nxt = 8'd0;
            w_cnt_clear_nxt = 8'd0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado    <= c_NORMAL;
            r_cnt_filt  <= 8'd0;
            r_cnt_blink <= 8'd0;
            r_cnt_clear <= 8'd0;
            r_led       <= 1'b0;
            r_alarma    <= 1'b0;
        end else begin
            r_estado    <= w_estado_nxt;
            r_cnt_filt  <= w_cnt_filt_nxt;
            r_cnt_blink <= w_cnt_blink_nxt;
            r_cnt_clear <= w_cnt_clear_nxt;
            r_led       <= w_led_nxt;
            r_alarma    <= w_alarma_nxt;
        end
    end

    assign led_o    = r_led;
    assign alarma_o = r_alarma;
    assign estado_o = r_estado;

`ifdef ALARMA_CONTADOR_EN
    logic [7:0] r_eventos;

    // Saturating count of alarm entries; ack and clearing leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eventos <= 8'd0;
        end else if (w_entra_alarma && (r_eventos != 8'hFF)) begin
            r_eventos <= r_eventos + 8'd1;
        end
    end

    assign eventos_o = r_eventos;
`endif

endmodule
`default_nettype wire

// File: doc/indicador_alarma_descarga.md
Name: indicador_alarma_descarga

Overview:
- Downstream consumer of the battery discharge identifier's 1-bit discharge flag.
- Filters the flag over a slow sample strobe so a momentary dip does not raise an alarm.
- Drives the user LED: blinks while the alarm is unacknowledged, holds steady once acknowledged, and clears after the battery level recovers.
- Sits between the discharge identifier and the board LED pin.

Parameters:
- FILTER_LEN, 4: consecutive flagged ticks required to raise the alarm. Legal range 1..255.
- BLINK_HALF, 2: ticks per blink half-period while in ALARMA. Legal range 1..255.
- CLEAR_LEN, 3: consecutive unflagged ticks required to clear the alarm. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tick_i  input  1  sample strobe, one clk cycle wide. The block acts only on cycles where tick_i=1.
- descarga_i  input  1  discharge flag from the identifier; sampled only when tick_i=1.
- ack_i  input  1  user acknowledge; sampled on every clk cycle.
- led_o  output  1  LED drive; registered.
- alarma_o  output  1  high in ALARMA or RECONOCIDA; registered.
- estado_o  output  2  current state encoding.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate, also mid-operation):
  - state=NORMAL.
  - All counters = 0.
  - led_o=0, alarma_o=0, estado_o=2'b00.
- States:
  - NORMAL = 00
  - PENDIENTE = 01
  - ALARMA = 10
  - RECONOCIDA = 11
- Internal counters: cnt_filt, cnt_blink, cnt_clear, each 8 bits.
- NORMAL (led_o=0):
  - Tick with descarga_i=1: cnt_filt=1. Go to PENDIENTE, or directly to ALARMA if FILTER_LEN=1.
  - Tick with descarga_i=0: no change.
- PENDIENTE (led_o=0, alarma_o=0):
  - Tick with descarga_i=0: cnt_filt=0, go to NORMAL.
  - Tick with descarga_i=1: cnt_filt increments.
  - On the tick that makes the count FILTER_LEN, go to ALARMA.
- Entering ALARMA (registered on that same edge):
  - led_o=1, alarma_o=1.
  - cnt_blink=0, cnt_clear=0, cnt_filt=0.
- ALARMA blink:
  - Each tick increments cnt_blink.
  - On the tick where cnt_blink=BLINK_HALF-1: toggle led_o and reset cnt_blink to 0.
  - Result: led_o is high for BLINK_HALF ticks, then low for BLINK_HALF ticks, repeating.
- ALARMA acknowledge:
  - ack_i=1 on any cycle: go to RECONOCIDA, led_o=1 steady, cnt_blink=0.
- Clear counting (ALARMA and RECONOCIDA):
  - Tick with descarga_i=0: cnt_clear increments.
  - Tick with descarga_i=1: cnt_clear=0.
  - On the tick making cnt_clear=CLEAR_LEN: go to NORMAL, led_o=0, alarma_o=0, all counters 0.
- RECONOCIDA:
  - led_o=1 steady.
  - ack_i is ignored.
  - Exits only through the clear condition above.
- Simultaneous events:
  - Clear completion and ack_i in the same cycle: clear wins; next state is NORMAL.
  - ack_i in the same cycle as a blink toggle: next state is RECONOCIDA with led_o=1.
- ack_i in NORMAL or PENDIENTE: no effect and not remembered.
- tick_i=0: all counters and led_o hold, except the ack_i transition, which needs no tick.
- Counter widths: 8 bits. Parameters outside 1..255 are illegal; the design need not handle them.
- Latency: every transition takes effect on the same clk edge that samples its qualifying tick or ack_i. The corresponding outputs are visible after that edge.

Optional Feature:
- Macro: ALARMA_CONTADOR_EN.
- Defined:
  - Adds output port eventos_o [7:0]: count of entries into ALARMA since reset.
  - Increments on the edge that enters ALARMA and saturates at 255.
  - Reset value is 0.
  - Not affected by ack_i or by clearing.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan (default parameters):
- Filter: rst_n low then high; 4 ticks with descarga_i=1 → estado_o 00→01→01→01→10; alarma_o=1 and led_o=1 after the 4th tick edge.
- Glitch rejection: 3 flagged ticks, 1 unflagged, 3 flagged → never reaches ALARMA; estado_o returns to 00 after the unflagged tick.
- Blink: in ALARMA with descarga_i held at 1 for 8 ticks → led_o sequence 1,1,0,0,1,1,0,0; alarma_o stays 1.
- Acknowledge and clear:
  - ack_i pulse in ALARMA → estado_o=11, led_o=1 steady.
  - 2 unflagged ticks, 1 flagged, 3 unflagged → returns to 00 only after the final 3rd consecutive unflagged tick; led_o=0.
- Simultaneity and reset:
  - ack_i asserted on the same cycle as the 3rd clear tick → estado_o=00.
  - rst_n pulsed low mid-ALARMA between clk edges → led_o=0 and estado_o=00 immediately, before the next clk edge.
- With ALARMA_CONTADOR_EN: 3 full alarm/clear cycles → eventos_o=3; a further 300 cycles → eventos_o holds at 255.
